// File: rtl/dsram_like_responder.sv
// Responder end of the CPU data-side SRAM-like bus, backed by a word-addressed
// on-chip RAM. Every accepted request gets exactly one data_ok pulse, LATENCY
// cycles after acceptance, and responses come back in request order. Writes
// respond with rdata = 0. Reads respond with the word as it stood before the
// acceptance edge.
module dsram_like_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [3:0]       PUSH_CNT = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(MAX_OUT);
    // With a one-cycle latency the response goes straight to the output
    // register and never occupies a queue slot.
    localparam bit BYPASS = (LATENCY == 1);

    // The output register is the last stage of each request's countdown, so a
    // queued entry leaves the queue on the edge that loads data_ok. An entry
    // fires when its countdown shows 1, i.e. one edge before it would reach 0.
    logic [31:0]          mem [WORDS];
    logic [31:0]          q_data [MAX_OUT];
    logic [3:0]           q_cnt  [MAX_OUT];
    logic [MAX_OUT-1:0]   q_vld;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                  accept_p0;
    logic [DEPTH_LOG2-1:0] widx_p0;
    logic [31:0]           rword_p0;
    logic [31:0]           entry_p0;
    logic                  push;
    logic                  pop;
    logic                  fire;
    logic [31:0]           fire_data;
    logic                  unused_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Acceptance stage: addr_ok looks only at reset and the registered count.
    assign addr_ok   = !reset && (count < FULL);
    assign accept_p0 = req && addr_ok;
    assign widx_p0   = addr[DEPTH_LOG2+1:2];
    assign rword_p0  = mem[widx_p0];
    assign entry_p0  = wr ? 32'd0 : rword_p0;

    assign push      = accept_p0 && !BYPASS;
    assign pop       = q_vld[rd_ptr] && (q_cnt[rd_ptr] == 4'd1);
    assign fire      = pop || (accept_p0 && BYPASS);
    assign fire_data = pop ? q_data[rd_ptr] : entry_p0;

    // Byte offset, size and the aliased upper address bits play no part in the access.
    assign unused_ok = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

    // Byte-lane RAM writes land on the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_p0 && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx_p0][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Queue occupancy: valid bits, wrapping pointers and the outstanding count.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_vld  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= next_ptr(rd_ptr);
            end
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue payload and per-entry countdown; the valid bits qualify them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUT; i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                q_data[i] <= entry_p0;
                q_cnt[i]  <= PUSH_CNT;
            end else if (q_vld[i] && (q_cnt[i] != 4'd0)) begin
                q_cnt[i] <= q_cnt[i] - 4'd1;
            end
        end
    end

    // Response stage: registered one-cycle data_ok; rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_ok <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            data_ok <= fire;
            if (fire) begin
                rdata <= fire_data;
            end
        end
    end

endmodule

// File: tb/tb_dsram_like_responder.sv
// Bench for dsram_like_responder. Three instances with different latencies
// share one stimulus bus; sel picks which instance receives req and whose
// outputs are observed. A scoreboard queue holds the expected data and the
// cycle each response is due in.
module tb_dsram_like_responder;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    int          sel = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        aok0, aok1, aok2, dok0, dok1, dok2;
    logic [31:0] rd0, rd1, rd2;
    logic        aok, dok;
    logic [31:0] rd;

    exp_t        sb[$];
    logic [31:0] model [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsram_like_responder #(.DEPTH_LOG2(10), .LATENCY(2), .MAX_OUT(2)) u_l2 (
        .clk(clk), .reset(reset), .req(req && sel == 0), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(aok0), .data_ok(dok0), .rdata(rd0));

    dsram_like_responder #(.DEPTH_LOG2(10), .LATENCY(4), .MAX_OUT(2)) u_l4 (
        .clk(clk), .reset(reset), .req(req && sel == 1), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(aok1), .data_ok(dok1), .rdata(rd1));

    dsram_like_responder #(.DEPTH_LOG2(10), .LATENCY(1), .MAX_OUT(2)) u_l1 (
        .clk(clk), .reset(reset), .req(req && sel == 2), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(aok2), .data_ok(dok2), .rdata(rd2));

    assign aok = (sel == 0) ? aok0 : (sel == 1) ? aok1 : aok2;
    assign dok = (sel == 0) ? dok0 : (sel == 1) ? dok1 : dok2;
    assign rd  = (sel == 0) ? rd0  : (sel == 1) ? rd1  : rd2;

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 4 : 1;
    endfunction

    function automatic int key_of(input int s, input logic [31:0] a);
        return s * 65536 + int'(a[11:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Record an accepted request in the scoreboard and the memory model.
    task automatic accept_req(input bit w, input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] d);
        exp_t e;
        int   k;
        k      = key_of(sel, a);
        e.data = w ? 32'd0 : model[k];
        e.due  = cyc + lat_of(sel);
        sb.push_back(e);
        if (w) begin
            logic [31:0] m;
            m = model.exists(k) ? model[k] : 32'd0;
            for (int i = 0; i < 4; i++) begin
                if (s[i]) m[8*i +: 8] = d[8*i +: 8];
            end
            model[k] = m;
        end
    endtask

    // Drive one request, holding it until accepted (bounded).
    task automatic issue(input bit w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input bit expect_now);
        int tries;
        tries = 0;
        @(negedge clk);
        req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d; size = 2'd2;
        #1;
        while (aok !== 1'b1 && tries < 40) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (expect_now) check("addr_ok_no_stall", 32'(tries), 32'd0);
        if (aok !== 1'b1) begin
            check("accept_timeout", {31'd0, aok}, 32'd1);
        end else begin
            accept_req(w, s, a, d);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0; wr = 1'b0; wstrb = 4'h0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: every data_ok must match the oldest expectation.
    always @(negedge clk) begin
        if (dok === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_data_ok", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", rd, e.data);
                check("response_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   pat [6];
        logic [31:0] a3 [4];
        int   n;

        // Reset state
        @(negedge clk);
        #1;
        check("addr_ok_in_reset", {31'd0, aok}, 32'd0);
        @(negedge clk);
        check("data_ok_in_reset", {31'd0, dok}, 32'd0);
        check("rdata_in_reset", rd, 32'd0);
        reset = 1'b0;
        #1;
        check("addr_ok_after_reset", {31'd0, aok}, 32'd1);

        // Write then read, LATENCY 2
        sel = 0;
        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
        drain();

        // Byte strobes, empty-strobe write, aliasing
        issue(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0);
        issue(1'b1, 4'h2, 32'h20, 32'h0000AA00, 1'b0);
        issue(1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        issue(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0);
        issue(1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        issue(1'b1, 4'hF, 32'h1234_0004, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 4'h0, 32'h0000_0004, 32'h0, 1'b0);
        drain();
        check("model_strobe_word", model[key_of(0, 32'h20)], 32'h1122AA44);

        // Queue full, LATENCY 4
        sel = 1;
        a3 = '{32'h100, 32'h104, 32'h108, 32'h10C};
        for (int i = 0; i < 4; i++) issue(1'b1, 4'hF, a3[i], $urandom(), 1'b0);
        drain();
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req = 1'b1; wr = 1'b0; wstrb = 4'h0; addr = a3[n < 4 ? n : 3];
            #1;
            check($sformatf("addr_ok_full_c%0d", c), {31'd0, aok}, {31'd0, pat[c]});
            if (aok === 1'b1 && n < 4) begin
                accept_req(1'b0, 4'h0, a3[n], 32'h0);
                n++;
            end
            @(posedge clk);
        end
        check("full_accepted", 32'(n), 32'd4);
        drain();

        // Back-to-back, LATENCY 1
        sel = 2;
        for (int i = 0; i < 8; i++) issue(1'b1, 4'hF, 32'h200 + 32'(4*i), $urandom(), 1'b1);
        for (int i = 0; i < 8; i++) issue(1'b0, 4'h0, 32'h200 + 32'(4*i), 32'h0, 1'b1);
        drain();

        // Reset with two reads pending, LATENCY 4
        sel = 1;
        issue(1'b0, 4'h0, 32'h100, 32'h0, 1'b1);
        issue(1'b0, 4'h0, 32'h104, 32'h0, 1'b1);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        sb.delete();
        #1;
        check("addr_ok_mid_reset", {31'd0, aok}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("data_ok_after_mid_reset", {31'd0, dok}, 32'd0);
        check("rdata_after_mid_reset", rd, 32'd0);
        check("addr_ok_after_mid_reset", {31'd0, aok}, 32'd1);
        repeat (8) @(negedge clk);
        check("rdata_still_zero", rd, 32'd0);
        issue(1'b0, 4'h0, 32'h108, 32'h0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
